// File: rtl/axi4_m_rd_if.sv
// axi4_m_rd_if: AXI4 read master front-end; one AR at a time -> one arbiter burst request, beats buffered in a FWFT FIFO toward R.
//   SYS_CLK_I/RESET_N_I       : clock, asynchronous active-low reset
//   ARADDR_I/ARLEN_I/ARVALID_I/ARREADY_O : AXI AR channel
//   RDATA_O/RVALID_O/RLAST_O/RREADY_I    : AXI R channel
//   R_REQ_O/R_START_ADDR_O/R_BURST_SIZE_O/R_ACK_I : arbiter read request
//   R_DATA_I/R_DATA_VALID_I   : arbiter read data, no backpressure
//   ERR_O                     : sticky unexpected-beat / overflow flag
module axi4_m_rd_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                      SYS_CLK_I,
  input  logic                      RESET_N_I,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR_I,
  input  logic [7:0]                ARLEN_I,
  input  logic                      ARVALID_I,
  output logic                      ARREADY_O,
  output logic [AXI_DATA_WIDTH-1:0] RDATA_O,
  output logic                      RVALID_O,
  output logic                      RLAST_O,
  input  logic                      RREADY_I,
  output logic                      R_REQ_O,
  output logic [AXI_ADDR_WIDTH-1:0] R_START_ADDR_O,
  output logic [7:0]                R_BURST_SIZE_O,
  input  logic                      R_ACK_I,
  input  logic [AXI_DATA_WIDTH-1:0] R_DATA_I,
  input  logic                      R_DATA_VALID_I,
  output logic                      ERR_O
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, DATA} state_t;
  state_t state, state_nx;
  logic [AXI_DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level, space;
  logic [7:0] beat_cnt;
  logic in_burst, full, push, pop, last, space_ok, ar_hs;
  assign ar_hs = state == IDLE && ARVALID_I && ARREADY_O;
  assign in_burst = state == REQ || state == DATA;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign push = R_DATA_VALID_I && in_burst && !full;
  assign pop = RVALID_O && RREADY_I;
  assign last = beat_cnt == R_BURST_SIZE_O;
  assign space = (AW+1)'(FIFO_DEPTH) - level;
  // free entries must cover ARLEN+1 beats, since the arbiter cannot be stalled
  assign space_ok = space > (AW+1)'(R_BURST_SIZE_O);
  assign RVALID_O = level != '0;
  // head entry is gated so the R outputs read zero whenever the FIFO is empty
  assign {RLAST_O, RDATA_O} = RVALID_O ? mem[rd_ptr] : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = ar_hs ? WAIT_SPACE : IDLE;
      WAIT_SPACE: state_nx = space_ok ? REQ : WAIT_SPACE;
      REQ:        state_nx = push && last ? IDLE : R_ACK_I ? DATA : REQ;
      DATA:       state_nx = push && last ? IDLE : DATA;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge SYS_CLK_I or negedge RESET_N_I)
    if (!RESET_N_I) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge SYS_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      ARREADY_O <= 1'b1;
      R_REQ_O <= 1'b0;
      R_START_ADDR_O <= '0;
      R_BURST_SIZE_O <= '0;
      beat_cnt <= '0;
      ERR_O <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      ARREADY_O <= state_nx == IDLE;
      R_REQ_O <= state_nx == REQ;
      if (ar_hs) begin
        R_START_ADDR_O <= ARADDR_I;
        R_BURST_SIZE_O <= ARLEN_I;
      end
      beat_cnt <= ar_hs ? '0 : push ? beat_cnt + 8'd1 : beat_cnt;
      if (R_DATA_VALID_I && (!in_burst || full)) ERR_O <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge SYS_CLK_I)
    if (push) mem[wr_ptr] <= {last, R_DATA_I};
endmodule

// File: tb/tb_axi4_m_rd_if.sv
// tb_axi4_m_rd_if: directed/randomized bench for axi4_m_rd_if with a queue-based expected R stream
module tb_axi4_m_rd_if;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [63:0] rdata;
  logic        rvalid, rlast;
  logic        rready = 1'b0;
  logic        r_req;
  logic [31:0] r_start_addr;
  logic [7:0]  r_burst_size;
  logic        r_ack = 1'b0;
  logic [63:0] r_data = '0;
  logic        r_data_valid = 1'b0;
  logic        err;
  int checks = 0;
  int failures = 0;
  logic [64:0] q[$];
  bit exp_push = 1'b0;
  bit exp_last = 1'b0;
  bit rr_toggle = 1'b0;
  always #5 clk = ~clk;
  axi4_m_rd_if dut (
    .SYS_CLK_I(clk), .RESET_N_I(rst_n),
    .ARADDR_I(araddr), .ARLEN_I(arlen), .ARVALID_I(arvalid), .ARREADY_O(arready),
    .RDATA_O(rdata), .RVALID_O(rvalid), .RLAST_O(rlast), .RREADY_I(rready),
    .R_REQ_O(r_req), .R_START_ADDR_O(r_start_addr), .R_BURST_SIZE_O(r_burst_size),
    .R_ACK_I(r_ack), .R_DATA_I(r_data), .R_DATA_VALID_I(r_data_valid), .ERR_O(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one clock: retire an R handshake against the model, record an expected push, advance, check RVALID
  task automatic cyc();
    logic [64:0] e;
    if (rvalid && rready) begin
      if (q.size() == 0) chk("r_unexpected", 64'(rvalid), 64'(0));
      else begin
        e = q.pop_front();
        chk("rdata", rdata, e[63:0]);
        chk("rlast", 64'(rlast), 64'(e[64]));
      end
    end
    if (exp_push) q.push_back({exp_last, r_data});
    @(posedge clk);
    @(negedge clk);
    r_data_valid = 1'b0;
    r_ack = 1'b0;
    exp_push = 1'b0;
    chk("rvalid", 64'(rvalid), 64'(q.size() != 0));
    if (rr_toggle) rready = ~rready;
  endtask
  task automatic beat(input logic [63:0] d, input bit l, input bit ack);
    r_data_valid = 1'b1;
    r_data = d;
    exp_push = 1'b1;
    exp_last = l;
    r_ack = ack;
    cyc();
  endtask
  task automatic ar(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    araddr = a;
    arlen = len;
    arvalid = 1'b1;
    while (!arready && n < 1000) begin cyc(); n++; end
    chk("ar_ready_wait", 64'(arready), 64'(1));
    cyc();
    arvalid = 1'b0;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!r_req && n < 2000) begin cyc(); n++; end
    chk("req_wait", 64'(r_req), 64'(1));
  endtask
  task automatic send(input int len, input int gap, input bit ack_first, input bit fixed, input logic [63:0] base);
    repeat (gap) cyc();
    if (!ack_first) begin
      r_ack = 1'b1;
      cyc();
      chk("req_drop", 64'(r_req), 64'(0));
    end
    for (int i = 0; i <= len; i++)
      beat(fixed ? base + 64'(i) : {$urandom, $urandom}, i == len, ack_first && i == 0);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin cyc(); n++; end
    chk("drain", 64'(q.size()), 64'(0));
  endtask
  task automatic chk_reset_vals();
    chk("rst_arready", 64'(arready), 64'(1));
    chk("rst_req", 64'(r_req), 64'(0));
    chk("rst_addr", 64'(r_start_addr), 64'(0));
    chk("rst_size", 64'(r_burst_size), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rlast", 64'(rlast), 64'(0));
    chk("rst_rdata", rdata, 64'(0));
    chk("rst_err", 64'(err), 64'(0));
  endtask
  initial begin
    repeat (3) cyc();
    chk_reset_vals();
    rst_n = 1'b1;
    cyc();
    // 1: ARLEN=3, ack two cycles after request, fixed data A0..A3
    rready = 1'b1;
    ar(32'h1000, 8'd3);
    chk("t1_addr", 64'(r_start_addr), 64'h1000);
    chk("t1_size", 64'(r_burst_size), 64'(3));
    chk("t1_req_t1", 64'(r_req), 64'(0));
    cyc();
    chk("t1_req_t2", 64'(r_req), 64'(1));
    cyc();
    cyc();
    chk("t1_req_hold", 64'(r_req), 64'(1));
    send(3, 0, 1'b0, 1'b1, 64'hA0);
    chk("t1_arready", 64'(arready), 64'(1));
    drain();
    // 2: ARLEN=0, beat together with ack -> straight back to IDLE
    ar($urandom, 8'd0);
    wait_req();
    send(0, 0, 1'b1, 1'b0, '0);
    chk("t2_arready", 64'(arready), 64'(1));
    chk("t2_req", 64'(r_req), 64'(0));
    drain();
    // 3: fill FIFO with 256 beats, second burst waits for 16 pops
    rready = 1'b0;
    ar($urandom, 8'd255);
    wait_req();
    send(255, $urandom_range(0, 3), 1'b0, 1'b0, '0);
    chk("t3_full", 64'(q.size()), 64'(256));
    ar($urandom, 8'd15);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t3_req_blocked", 64'(r_req), 64'(0));
    end
    rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("t3_req_pop", 64'(r_req), 64'(0));
    end
    cyc();
    chk("t3_req_rise", 64'(r_req), 64'(1));
    send(15, 1, 1'b0, 1'b0, '0);
    drain();
    chk("t3_err", 64'(err), 64'(0));
    // 4: back-to-back ARLEN=7 bursts with RREADY toggling
    rr_toggle = 1'b1;
    ar($urandom, 8'd7);
    wait_req();
    send(7, $urandom_range(0, 2), 1'b0, 1'b0, '0);
    chk("t4_draining", 64'(rvalid), 64'(1));
    ar($urandom, 8'd7);
    wait_req();
    send(7, 0, 1'b0, 1'b0, '0);
    drain();
    rr_toggle = 1'b0;
    rready = 1'b1;
    chk("t4_err", 64'(err), 64'(0));
    // 5: stray beat in IDLE
    r_data_valid = 1'b1;
    r_data = {$urandom, $urandom};
    cyc();
    chk("t5_err", 64'(err), 64'(1));
    repeat (3) cyc();
    chk("t5_err_hold", 64'(err), 64'(1));
    // 6: asynchronous reset mid-burst, then a clean ARLEN=1 burst
    rready = 1'b0;
    ar($urandom, 8'd7);
    wait_req();
    r_ack = 1'b1;
    cyc();
    beat({$urandom, $urandom}, 1'b0, 1'b0);
    beat({$urandom, $urandom}, 1'b0, 1'b0);
    chk("t6_nonempty", 64'(rvalid), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    rready = 1'b1;
    ar(32'h2000, 8'd1);
    chk("t6_addr", 64'(r_start_addr), 64'h2000);
    wait_req();
    send(1, 1, 1'b0, 1'b0, '0);
    drain();
    chk("t6_err", 64'(err), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_m_rd_if.md
Name: axi4_m_rd_if

Overview:
Read-direction companion to the AXI4 write-side master interface of the DDR AXI4 arbiter. It accepts one AXI4 read address (AR) transaction at a time and issues a single-burst read request to the arbiter. Returned beats go into an internal FIFO, tagged with RLAST, and drain to the AXI4 R channel under RREADY backpressure. The arbiter read-data path has no backpressure, so no request is issued until the FIFO has space for the whole burst.

Parameters:
AXI_DATA_WIDTH, 64, width of RDATA and arbiter read data.
AXI_ADDR_WIDTH, 32, width of ARADDR and request start address.
FIFO_DEPTH, 256, FIFO entries; legal values are powers of two ≥256, so any ARLEN fits.

Ports:
SYS_CLK_I  in  1  single clock.
RESET_N_I  in  1  asynchronous active-low reset.
ARADDR_I  in  AXI_ADDR_WIDTH  AXI read start address.
ARLEN_I  in  8  beats minus one.
ARVALID_I  in  1  AR valid.
ARREADY_O  out  1  AR ready.
RDATA_O  out  AXI_DATA_WIDTH  read data.
RVALID_O  out  1  R valid.
RLAST_O  out  1  last beat of burst.
RREADY_I  in  1  R ready.
R_REQ_O  out  1  read request to arbiter.
R_START_ADDR_O  out  AXI_ADDR_WIDTH  latched ARADDR.
R_BURST_SIZE_O  out  8  latched ARLEN (beats minus one).
R_ACK_I  in  1  arbiter grant of R_REQ_O.
R_DATA_I  in  AXI_DATA_WIDTH  arbiter read data.
R_DATA_VALID_I  in  1  arbiter data valid, no backpressure.
ERR_O  out  1  sticky: unexpected beat or FIFO overflow.

Behaviour:
- Reset (asynchronous, RESET_N_I=0): state=IDLE, ARREADY_O=1, R_REQ_O=0, R_START_ADDR_O=0, R_BURST_SIZE_O=0, RVALID_O=0, RLAST_O=0, RDATA_O=0, ERR_O=0. FIFO pointers, level and beat counter cleared; any in-flight data is discarded. The arbiter must be reset in the same domain.
- FSM states: IDLE, WAIT_SPACE, REQ, DATA. ARREADY_O is registered and equals 1 only in IDLE.
- IDLE: on ARVALID_I&ARREADY_O, latch ARADDR_I into R_START_ADDR_O and ARLEN_I into R_BURST_SIZE_O, clear beat counter, go to WAIT_SPACE.
- WAIT_SPACE: when (FIFO_DEPTH − level) ≥ R_BURST_SIZE_O+1, set R_REQ_O=1 (registered) and go to REQ. Otherwise stay.
- REQ: hold R_REQ_O=1 until R_ACK_I=1. On that cycle clear R_REQ_O (low the next cycle) and go to DATA.
- Beats are accepted in REQ and DATA, including a beat in the same cycle as R_ACK_I. Each accepted beat is pushed as {last, R_DATA_I}, where last=1 when beat counter == R_BURST_SIZE_O, and the counter increments.
- On the push of the last beat, go to IDLE. ARREADY_O=1 the next cycle. A new AR is accepted while the previous burst is still draining.
- R_DATA_VALID_I in IDLE or WAIT_SPACE: the beat is dropped, ERR_O←1, no state change.
- Push while FIFO full: the beat is dropped and ERR_O←1. The space check makes this unreachable in legal use. ERR_O clears only on reset.
- R side is first-word-fall-through: RVALID_O = FIFO not empty; RDATA_O/RLAST_O come from the head entry. Pop on RVALID_O&RREADY_I.
- Simultaneous push and pop: level unchanged, both succeed.
- Level counter is clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - AR handshake at cycle T → R_REQ_O high at T+2 if space is available.
  - Arbiter beat at cycle k with FIFO empty → RVALID_O high at k+1.
- Exactly one burst is outstanding to the arbiter at any time.

Test Plan:
1. ARADDR=0x1000, ARLEN=3, R_ACK_I 2 cycles after R_REQ_O, 4 back-to-back beats 0xA0..0xA3, RREADY=1 → R_START_ADDR_O=0x1000, R_BURST_SIZE_O=3; RDATA 0xA0..0xA3 each one cycle after input; RLAST only with 0xA3; ARREADY_O=1 the cycle after the 4th push.
2. ARLEN=0, beat in same cycle as R_ACK_I → single RVALID with RLAST=1; FSM REQ→IDLE directly.
3. RREADY=0, ARLEN=255 burst fills FIFO (level 256), then ARLEN=15 accepted → R_REQ_O stays 0 until 16 pops, rises 1 cycle after level reaches 240; all 272 beats delivered in order, RLAST on beats 256 and 272.
4. Back-to-back ARs (ARLEN=7 then ARLEN=7), RREADY toggling 1/0 → second AR accepted while first is draining; no data loss; ERR_O=0.
5. R_DATA_VALID_I pulse in IDLE → ERR_O=1 next cycle, RVALID_O stays 0, ERR_O holds until reset.
6. RESET_N_I asserted mid-burst (beat 2 of 8, FIFO non-empty) → all outputs at reset values immediately (asynchronous); after release, new AR ARLEN=1 completes normally with no stale data.
